// File: rtl/mem_arbiter_pit_pkg.sv
// rtl/mem_arbiter_pit_pkg.sv - shared state encodings and defaults for the memory arbiter
package mem_arbiter_pit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_e;

    localparam int BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_burst_cnt_pit.sv
// rtl/arb_burst_cnt_pit.sv - 4-bit saturating burst counter with clear and increment
module arb_burst_cnt_pit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'd15)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter_pit.sv
// rtl/mem_arbiter_pit.sv - two-port memory arbiter with burst-limited round robin
module mem_arbiter_pit
    import mem_arbiter_pit_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [7:0] mem_addr,
    output logic       mem_write,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout,
    output logic       busy
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic [3:0] burst_cnt;
    logic       at_limit;

    // >= so a count that saturated while uncontended still hands over at once
    assign at_limit = (burst_cnt >= 4'(BURST_MAX - 1));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = last_q ? G0 : G1;
                else if (req0)    state_d = G0;
                else if (req1)    state_d = G1;
            end
            G0: begin
                if (!req0)                state_d = req1 ? G1 : IDLE;
                else if (req1 && at_limit) state_d = G1;
            end
            G1: begin
                if (!req1)                state_d = req0 ? G0 : IDLE;
                else if (req0 && at_limit) state_d = G0;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d != state_q) && (state_d == G0)) last_d = 1'b0;
        if ((state_d != state_q) && (state_d == G1)) last_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    arb_burst_cnt_pit u_burst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .inc (ack0 || ack1),
        .cnt (burst_cnt)
    );

    assign gnt0 = (state_q == G0);
    assign gnt1 = (state_q == G1);
    assign ack0 = gnt0 && req0;
    assign ack1 = gnt1 && req1;
    assign busy = gnt0 || gnt1;

    always_comb begin
        mem_addr  = 8'h00;
        mem_din   = 8'h00;
        mem_write = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_din   = wdata0;
            mem_write = we0 && req0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_din   = wdata1;
            mem_write = we1 && req1;
        end
    end

    assign rdata = (ack0 || ack1) ? mem_dout : 8'h00;

endmodule

// File: tb/tb_mem_arbiter_pit.sv
// tb/tb_mem_arbiter_pit.sv - directed self-checking bench for mem_arbiter_pit
module tb_mem_arbiter_pit;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, ack0, ack1, mem_write, busy;
    logic [7:0] rdata, mem_addr, mem_din, mem_dout;

    int vectors = 0;
    int miscompares = 0;
    int w0 = 0;
    int w1 = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write && mem_addr[7]) mem[mem_addr] <= mem_din;
    end

    assign mem_dout = mem[mem_addr];

    mem_arbiter_pit #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        clear_inputs();
        step();
        rst = 1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[8'h85] = 8'hA5;
        mem[8'h81] = 8'h11;

        // reset holds everything quiet even with live requests
        rst = 0;
        clear_inputs();
        req0 = 1; we0 = 1; addr0 = 8'h85; wdata0 = 8'hFF; req1 = 1; we1 = 1;
        step(); step();
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_ack", {ack0, ack1}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_rdata", rdata, 8'h00);

        // single read from port 0
        clear_inputs();
        rst = 1;
        #1;
        req0 = 1; we0 = 0; addr0 = 8'h85;
        #1;
        chk("rd_pre_gnt0", gnt0, 0);
        step();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_gnt1", gnt1, 0);
        chk("rd_ack0", ack0, 1);
        chk("rd_busy", busy, 1);
        chk("rd_mem_addr", mem_addr, 8'h85);
        chk("rd_rdata", rdata, 8'hA5);

        // contention: port 0 wins the first tie, hands over after BURST_MAX acks
        do_reset();
        req0 = 1; addr0 = 8'h10; req1 = 1; addr1 = 8'h20;
        step();
        chk("tie_gnt0", {gnt0, gnt1}, 2'b10);
        chk("tie_ack0", ack0, 1);
        chk("tie_mem_addr", mem_addr, 8'h10);
        chk("tie_rdata", rdata, 8'h4A);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("burst0_%0d", i), {gnt0, gnt1}, 2'b10);
        end
        step();
        chk("switch_to_g1", {gnt0, gnt1}, 2'b01);
        chk("switch_ack1", ack1, 1);
        chk("switch_mem_addr", mem_addr, 8'h20);
        chk("switch_rdata", rdata, 8'h7A);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("burst1_%0d", i), {gnt0, gnt1}, 2'b01);
        end
        step();
        chk("switch_back_g0", {gnt0, gnt1}, 2'b10);

        // one-cycle write from port 1, read back through port 0
        do_reset();
        req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 8'h3C;
        #1;
        chk("wr_idle_mem_write", mem_write, 0);
        step();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_addr", mem_addr, 8'h80);
        chk("wr_mem_din", mem_din, 8'h3C);
        step();
        req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 8'h80;
        #1;
        chk("wr_drop_mem_write", mem_write, 0);
        step();
        chk("rb_gnt0", {gnt0, gnt1}, 2'b10);
        chk("rb_mem_write", mem_write, 0);
        chk("rb_rdata", rdata, 8'h3C);

        // port 0 alone keeps the grant and the counter saturates
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("hold_%0d", i), {gnt0, gnt1}, 2'b10);
        end
        chk("hold_burst_cnt", dut.burst_cnt, 4'd15);

        // asynchronous reset in the middle of a port 1 write
        do_reset();
        req1 = 1; we1 = 1; addr1 = 8'h81; wdata1 = 8'h77;
        step();
        chk("arst_pre_gnt1", gnt1, 1);
        chk("arst_pre_mem_write", mem_write, 1);
        #2;
        rst = 0;
        #1;
        chk("arst_gnt", {gnt0, gnt1}, 2'b00);
        chk("arst_ack", {ack0, ack1}, 2'b00);
        chk("arst_mem_write", mem_write, 0);
        chk("arst_mem_addr", mem_addr, 8'h00);
        chk("arst_mem_din", mem_din, 8'h00);
        chk("arst_busy", busy, 0);
        step();
        chk("arst_ram_unchanged", mem[8'h81], 8'h11);
        req0 = 1; req1 = 1; we1 = 0;
        rst = 1;
        #1;
        step();
        chk("arst_next_tie", {gnt0, gnt1}, 2'b10);

        // random traffic: exclusivity, ack only with grant, bounded waits
        do_reset();
        w0 = 0;
        w1 = 0;
        for (int n = 0; n < 2000; n++) begin
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            addr0  = 8'($urandom_range(0, 255));
            addr1  = 8'($urandom_range(0, 255));
            wdata0 = 8'($urandom_range(0, 255));
            wdata1 = 8'($urandom_range(0, 255));
            #1;
            w0 = (req0 && !gnt0) ? w0 + 1 : 0;
            w1 = (req1 && !gnt1) ? w1 + 1 : 0;
            chk("rnd_mutex", gnt0 & gnt1, 0);
            chk("rnd_ack_wo_gnt", (ack0 & ~gnt0) | (ack1 & ~gnt1), 0);
            chk("rnd_wait", (w0 > BURST_MAX + 1) || (w1 > BURST_MAX + 1), 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
